// File: rtl/axi4_s_read_subordinate_if.sv
// AXI4 read address and read data channels between one manager and one subordinate.
// Handshake: a transfer happens on a rising clock edge where valid and ready are both 1;
// valid never waits for ready, and payload is held stable while valid=1 and ready=0.
interface axi4_s_read_subordinate_if #(
  parameter int ADDRESS_SIZE = 32,
  parameter int DATA_SIZE    = 32
);
  logic [ADDRESS_SIZE-1:0] s_axi_araddr;
  logic [7:0]              s_axi_arlen;
  logic [2:0]              s_axi_arsize;
  logic [1:0]              s_axi_arburst;
  logic                    s_axi_arvalid;
  logic                    s_axi_arready;
  logic [DATA_SIZE-1:0]    s_axi_rdata;
  logic [1:0]              s_axi_rresp;
  logic                    s_axi_rlast;
  logic                    s_axi_rvalid;
  logic                    s_axi_rready;

  modport master (
    output s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid, s_axi_rready,
    input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid
  );

  modport slave (
    input  s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid, s_axi_rready,
    output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid
  );
endinterface

// File: rtl/axi4_s_read_subordinate.sv
// AXI4 read subordinate: one outstanding FIXED/INCR/WRAP burst served from a word memory
// loaded through a sideband write port; illegal requests and out-of-range beats return SLVERR.
module axi4_s_read_subordinate #(
  parameter int ADDRESS_SIZE = 32,
  parameter int DATA_SIZE    = 32,
  parameter int DEPTH        = 256,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic                     aclk,
  input  logic                     areset,
  axi4_s_read_subordinate_if.slave axi,
  input  logic                     mem_we,
  input  logic [AW-1:0]            mem_waddr,
  input  logic [DATA_SIZE-1:0]     mem_wdata,
  output logic                     dbg_state_o
);
  localparam int B  = DATA_SIZE / 8;
  localparam int SB = $clog2(B);
  localparam logic [ADDRESS_SIZE-1:0] BYTES      = ADDRESS_SIZE'(B);
  localparam logic [ADDRESS_SIZE-1:0] ALIGN_MASK = ~(BYTES - ADDRESS_SIZE'(1));

  typedef enum logic {ST_IDLE, ST_BURST} state_e;

  state_e                  state_q;
  logic [ADDRESS_SIZE-1:0] addr_q, wrap_mask_q;
  logic [7:0]              len_q, cnt_q;
  logic [1:0]              burst_q;
  logic                    err_q;
  logic                    arready_q, rvalid_q, rlast_q;
  logic [1:0]              rresp_q;
  logic [DATA_SIZE-1:0]    rdata_q;
  logic [DATA_SIZE-1:0]    mem_q [DEPTH];

  logic                    ar_fire, r_fire, req_err, beat_err, beat_in_range;
  logic [ADDRESS_SIZE-1:0] req_mask, beat_addr, beat_mask, next_addr;
  logic [1:0]              beat_burst, beat_resp;
  logic [AW-1:0]           beat_word;
  logic [DATA_SIZE-1:0]    beat_data;

  assign ar_fire = axi.s_axi_arvalid && arready_q;
  assign r_fire  = rvalid_q && axi.s_axi_rready;

  // In idle the first beat is built straight from the AR channel so it is presented the
  // cycle after the handshake; afterwards the latched request drives the beat.
  always_comb begin
    req_err = (axi.s_axi_arsize != 3'(SB)) || (axi.s_axi_arburst == 2'b11) ||
              ((axi.s_axi_arburst == 2'b10) &&
               !(axi.s_axi_arlen inside {8'd1, 8'd3, 8'd7, 8'd15}));
    req_mask = ((ADDRESS_SIZE'(axi.s_axi_arlen) + ADDRESS_SIZE'(1)) << SB) - ADDRESS_SIZE'(1);
    if (state_q == ST_IDLE) begin
      beat_addr  = (axi.s_axi_arburst == 2'b00) ? axi.s_axi_araddr
                                                : (axi.s_axi_araddr & ALIGN_MASK);
      beat_burst = axi.s_axi_arburst;
      beat_mask  = req_mask;
      beat_err   = req_err;
    end else begin
      beat_addr  = addr_q;
      beat_burst = burst_q;
      beat_mask  = wrap_mask_q;
      beat_err   = err_q;
    end
    case (beat_burst)
      2'b01:   next_addr = beat_addr + BYTES;
      2'b10:   next_addr = (beat_addr & ~beat_mask) | ((beat_addr + BYTES) & beat_mask);
      default: next_addr = beat_addr;
    endcase
    beat_word     = beat_addr[SB +: AW];
    beat_in_range = (beat_addr >> (SB + AW)) == '0;
    if (beat_err || !beat_in_range) begin
      beat_data = '0;
      beat_resp = 2'b10;
    end else begin
      beat_data = mem_q[beat_word];
      beat_resp = 2'b00;
    end
  end

  always_ff @(posedge aclk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= ST_IDLE;
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;
      rresp_q     <= 2'b00;
      rdata_q     <= '0;
      addr_q      <= '0;
      wrap_mask_q <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      burst_q     <= 2'b00;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          arready_q <= 1'b1;
          if (ar_fire) begin
            state_q     <= ST_BURST;
            arready_q   <= 1'b0;
            len_q       <= axi.s_axi_arlen;
            burst_q     <= axi.s_axi_arburst;
            err_q       <= req_err;
            wrap_mask_q <= req_mask;
            cnt_q       <= '0;
            addr_q      <= next_addr;
            rvalid_q    <= 1'b1;
            rdata_q     <= beat_data;
            rresp_q     <= beat_resp;
            rlast_q     <= (axi.s_axi_arlen == 8'd0);
          end
        end
        ST_BURST: begin
          if (r_fire) begin
            if (rlast_q) begin
              state_q   <= ST_IDLE;
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
            end else begin
              cnt_q   <= cnt_q + 8'd1;
              addr_q  <= next_addr;
              rdata_q <= beat_data;
              rresp_q <= beat_resp;
              rlast_q <= ((cnt_q + 8'd1) == len_q);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign axi.s_axi_arready = arready_q;
  assign axi.s_axi_rvalid  = rvalid_q;
  assign axi.s_axi_rdata   = rdata_q;
  assign axi.s_axi_rresp   = rresp_q;
  assign axi.s_axi_rlast   = rlast_q;
  assign dbg_state_o       = (state_q == ST_BURST);
endmodule

// File: tb/tb_axi4_s_read_subordinate.sv
// Bench for axi4_s_read_subordinate: directed vector table, hand-written corner sequences
// and random bursts checked against an address-arithmetic reference model.
module tb_axi4_s_read_subordinate;
  localparam int AS    = 32;
  localparam int DS    = 32;
  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int B     = 4;
  localparam int W     = DS + 3;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          mem_we = 1'b0;
  logic [AW-1:0] mem_waddr = '0;
  logic [DS-1:0] mem_wdata = '0;
  logic          dbg_state;

  axi4_s_read_subordinate_if #(.ADDRESS_SIZE(AS), .DATA_SIZE(DS)) axi ();

  axi4_s_read_subordinate #(.ADDRESS_SIZE(AS), .DATA_SIZE(DS), .DEPTH(DEPTH)) dut (
    .aclk        (aclk),
    .areset      (areset),
    .axi         (axi),
    .mem_we      (mem_we),
    .mem_waddr   (mem_waddr),
    .mem_wdata   (mem_wdata),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  always #5 aclk = ~aclk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  // scoreboard
  int            total = 0;
  int            bad   = 0;
  logic [W-1:0]  exp_q[$];
  logic [DS-1:0] ref_mem [DEPTH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // reference model: beat addresses from plain arithmetic on the request
  task automatic model_burst(input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst);
    bit            err;
    logic [31:0]   a0, base, a;
    int unsigned   win, word;
    logic [DS-1:0] d;
    logic [1:0]    r;
    err  = (size != 3'd2) || (burst == 2'b11) ||
           (burst == 2'b10 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
    a0   = addr - (addr % B);
    win  = (int'(len) + 1) * B;
    base = a0 - (a0 % win);
    for (int i = 0; i <= int'(len); i++) begin
      case (burst)
        2'b00:   a = addr;
        2'b10:   a = base + ((a0 - base + 32'(i * B)) % win);
        default: a = a0 + 32'(i * B);
      endcase
      word = a / B;
      if (err || word >= DEPTH) begin
        d = '0;
        r = 2'b10;
      end else begin
        d = ref_mem[word];
        r = 2'b00;
      end
      exp_q.push_back({d, r, (i == int'(len))});
    end
  endtask

  // driver tasks (all start and end at posedge+1)
  task automatic mem_write(input int idx, input logic [DS-1:0] d);
    mem_we    = 1'b1;
    mem_waddr = AW'(idx);
    mem_wdata = d;
    @(posedge aclk);
    #1;
    mem_we    = 1'b0;
    ref_mem[idx] = d;
  endtask

  task automatic run_burst(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input bit stall, input string tag,
                           output int nbeats, output logic [W-1:0] first_got);
    logic [W-1:0] got, exp, held;
    bit           holding, done;
    int           cyc;
    nbeats    = 0;
    first_got = '0;
    model_burst(addr, len, size, burst);
    axi.s_axi_araddr  = addr;
    axi.s_axi_arlen   = len;
    axi.s_axi_arsize  = size;
    axi.s_axi_arburst = burst;
    axi.s_axi_arvalid = 1'b1;
    axi.s_axi_rready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    cyc = 0;
    @(negedge aclk);
    while (!axi.s_axi_arready && cyc < 20) begin
      @(negedge aclk);
      cyc++;
    end
    check({tag, " ar_wait"}, 64'(cyc < 20), 64'd1);
    @(posedge aclk);
    #1;
    axi.s_axi_arvalid = 1'b0;
    if (cyc >= 20) begin
      exp_q.delete();
      return;
    end
    holding = 1'b0;
    done    = 1'b0;
    for (cyc = 0; cyc < 600 && !done; cyc++) begin
      @(negedge aclk);
      if (cyc == 0) check({tag, " first_valid"}, 64'(axi.s_axi_rvalid), 64'd1);
      else if (!stall) check({tag, " no_bubble"}, 64'(axi.s_axi_rvalid), 64'd1);
      if (axi.s_axi_rvalid) begin
        got = {axi.s_axi_rdata, axi.s_axi_rresp, axi.s_axi_rlast};
        if (holding) check({tag, " stall_hold"}, 64'(got), 64'(held));
        if (axi.s_axi_rready) begin
          if (exp_q.size() == 0) begin
            check({tag, " extra_beat"}, 64'(exp_q.size()), 64'd1);
          end else begin
            exp = exp_q.pop_front();
            check($sformatf("%s beat%0d", tag, nbeats), 64'(got), 64'(exp));
          end
          if (nbeats == 0) first_got = got;
          nbeats++;
          holding = 1'b0;
          if (axi.s_axi_rlast) done = 1'b1;
        end else begin
          holding = 1'b1;
          held    = got;
        end
      end
      @(posedge aclk);
      #1;
      axi.s_axi_rready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    check({tag, " completed"}, 64'(done), 64'd1);
    check({tag, " leftover"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(negedge aclk);
    check({tag, " after_rvalid"}, 64'(axi.s_axi_rvalid), 64'd0);
    check({tag, " after_arready"}, 64'(axi.s_axi_arready), 64'd1);
    @(posedge aclk);
    #1;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    bit          stall;
    int          exp_beats;
    int          exp_word0;  // -1: first beat must be SLVERR with zero data
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                                  input logic [1:0] burst, input bit stall, input int nb,
                                  input int w0, input string name);
    vec_t v;
    v.addr = addr; v.len = len; v.size = size; v.burst = burst; v.stall = stall;
    v.exp_beats = nb; v.exp_word0 = w0; v.name = name;
    vecs.push_back(v);
  endfunction

  initial begin
    int            nb;
    logic [W-1:0]  fg, fexp;
    logic [DS-1:0] old2;
    bit            seen_last;
    logic [31:0]   ra;
    logic [7:0]    rl;
    logic [2:0]    rs;
    logic [1:0]    rb;

    axi.s_axi_araddr  = '0;
    axi.s_axi_arlen   = '0;
    axi.s_axi_arsize  = 3'd2;
    axi.s_axi_arburst = 2'b01;
    axi.s_axi_arvalid = 1'b0;
    axi.s_axi_rready  = 1'b0;

    // memory preload happens while reset is held
    @(posedge aclk);
    #1;
    for (int i = 0; i < DEPTH; i++) mem_write(i, $urandom);
    for (int i = 0; i < 4; i++) mem_write(i, DS'(10 + i));
    mem_write(5, 32'hDEADBEEF);
    @(negedge aclk);
    check("reset arready", 64'(axi.s_axi_arready), 64'd0);
    check("reset rvalid", 64'(axi.s_axi_rvalid), 64'd0);
    check("reset rlast", 64'(axi.s_axi_rlast), 64'd0);
    check("reset rresp", 64'(axi.s_axi_rresp), 64'd0);
    check("reset rdata", 64'(axi.s_axi_rdata), 64'd0);
    check("reset state", 64'(dbg_state), 64'd0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    check("post_reset arready", 64'(axi.s_axi_arready), 64'd1);
    @(posedge aclk);
    #1;

    // directed vector table
    add_vec(32'h14, 8'd0, 3'd2, 2'b01, 1'b0, 1, 5, "incr_single");
    add_vec(32'h00, 8'd3, 3'd2, 2'b01, 1'b1, 4, 0, "incr4_stall");
    add_vec(32'h18, 8'd3, 3'd2, 2'b10, 1'b0, 4, 6, "wrap4");
    add_vec(32'h18, 8'd2, 3'd2, 2'b00, 1'b0, 3, 6, "fixed3");
    add_vec(32'h00, 8'd3, 3'd1, 2'b01, 1'b0, 4, -1, "err_size");
    add_vec(32'h00, 8'd1, 3'd2, 2'b11, 1'b1, 2, -1, "err_burst");
    add_vec(32'h18, 8'd2, 3'd2, 2'b10, 1'b0, 3, -1, "err_wraplen");
    add_vec(32'(255 * 4), 8'd1, 3'd2, 2'b01, 1'b0, 2, 255, "incr_cross_depth");
    add_vec(32'h34, 8'd7, 3'd2, 2'b10, 1'b1, 8, 13, "wrap8_stall");
    add_vec(32'h3F0, 8'd15, 3'd2, 2'b10, 1'b0, 16, 252, "wrap16");
    add_vec(32'hFFFFFFF8, 8'd3, 3'd2, 2'b01, 1'b0, 4, -1, "incr_addr_wrap");
    add_vec(32'h15, 8'd0, 3'd2, 2'b00, 1'b0, 1, 5, "fixed_unaligned");

    foreach (vecs[k]) begin
      run_burst(vecs[k].addr, vecs[k].len, vecs[k].size, vecs[k].burst, vecs[k].stall,
                vecs[k].name, nb, fg);
      check({vecs[k].name, " nbeats"}, 64'(nb), 64'(vecs[k].exp_beats));
      if (vecs[k].exp_word0 < 0) fexp = {DS'(0), 2'b10, (vecs[k].len == 8'd0)};
      else fexp = {ref_mem[vecs[k].exp_word0], 2'b00, (vecs[k].len == 8'd0)};
      check({vecs[k].name, " first"}, 64'(fg), 64'(fexp));
    end

    // sideband write to word 2 in the cycle its beat loads: old data expected
    old2 = ref_mem[2];
    axi.s_axi_araddr  = 32'h0;
    axi.s_axi_arlen   = 8'd3;
    axi.s_axi_arsize  = 3'd2;
    axi.s_axi_arburst = 2'b01;
    axi.s_axi_arvalid = 1'b1;
    axi.s_axi_rready  = 1'b1;
    @(negedge aclk);
    check("coll arready", 64'(axi.s_axi_arready), 64'd1);
    @(posedge aclk);
    #1;
    axi.s_axi_arvalid = 1'b0;
    @(negedge aclk);
    check("coll state", 64'(dbg_state), 64'd1);
    @(posedge aclk);
    #1;
    mem_we    = 1'b1;
    mem_waddr = AW'(2);
    mem_wdata = 32'hAA;
    @(posedge aclk);
    #1;
    mem_we = 1'b0;
    @(negedge aclk);
    check("coll old_data", 64'(axi.s_axi_rdata), 64'(old2));
    ref_mem[2] = 32'hAA;
    seen_last = 1'b0;
    for (int c = 0; c < 10 && !seen_last; c++) begin
      if (axi.s_axi_rvalid && axi.s_axi_rlast) seen_last = 1'b1;
      else @(negedge aclk);
    end
    check("coll last_seen", 64'(seen_last), 64'd1);
    check("coll last_data", 64'(axi.s_axi_rdata), 64'(ref_mem[3]));
    @(posedge aclk);
    #1;
    run_burst(32'h8, 8'd0, 3'd2, 2'b01, 1'b0, "coll_reread", nb, fg);
    check("coll new_data", 64'(fg[W-1:3]), 64'hAA);

    // reset in the middle of an 8-beat burst
    axi.s_axi_araddr  = 32'h0;
    axi.s_axi_arlen   = 8'd7;
    axi.s_axi_arsize  = 3'd2;
    axi.s_axi_arburst = 2'b01;
    axi.s_axi_arvalid = 1'b1;
    axi.s_axi_rready  = 1'b1;
    @(negedge aclk);
    @(posedge aclk);
    #1;
    axi.s_axi_arvalid = 1'b0;
    @(negedge aclk);
    check("rst_mid beat0", 64'(axi.s_axi_rdata), 64'(ref_mem[0]));
    @(posedge aclk);
    @(negedge aclk);
    check("rst_mid beat1", 64'(axi.s_axi_rdata), 64'(ref_mem[1]));
    @(posedge aclk);
    #1;
    areset = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    check("rst_mid rvalid", 64'(axi.s_axi_rvalid), 64'd0);
    check("rst_mid rlast", 64'(axi.s_axi_rlast), 64'd0);
    check("rst_mid rdata", 64'(axi.s_axi_rdata), 64'd0);
    check("rst_mid rresp", 64'(axi.s_axi_rresp), 64'd0);
    check("rst_mid arready", 64'(axi.s_axi_arready), 64'd0);
    @(posedge aclk);
    #1;
    mem_write(7, 32'h5A5A0007);
    areset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge aclk);
      check($sformatf("rst_mid quiet%0d", c), 64'(axi.s_axi_rvalid), 64'd0);
      if (c >= 1) check($sformatf("rst_mid arready%0d", c), 64'(axi.s_axi_arready), 64'd1);
    end
    @(posedge aclk);
    #1;
    run_burst(32'h0, 8'd7, 3'd2, 2'b01, 1'b0, "rst_mid_reread", nb, fg);

    // random bursts against the model
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 3) == 0) mem_write($urandom_range(0, DEPTH - 1), $urandom);
      rb = 2'($urandom_range(0, 9) < 1 ? 3 : $urandom_range(0, 2));
      if (rb == 2'b10 && $urandom_range(0, 4) != 0) begin
        case ($urandom_range(0, 3))
          0: rl = 8'd1;
          1: rl = 8'd3;
          2: rl = 8'd7;
          default: rl = 8'd15;
        endcase
      end else begin
        rl = 8'($urandom_range(0, 15));
      end
      rs = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
      case ($urandom_range(0, 3))
        0: ra = 32'($urandom_range(0, DEPTH * B + 63));
        1: ra = 32'($urandom_range((DEPTH - 8) * B, (DEPTH + 8) * B));
        2: ra = $urandom;
        default: ra = 32'($urandom_range(0, DEPTH - 1) * B);
      endcase
      run_burst(ra, rl, rs, rb, 1'($urandom_range(0, 1)), $sformatf("rand%0d", it), nb, fg);
      check($sformatf("rand%0d nbeats", it), 64'(nb), 64'(int'(rl) + 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi4_s_read_subordinate.md
# axi4_s_read_subordinate

AXI4 read-channel subordinate: accepts one read address request at a time and returns the burst from an internal word-addressed memory. The memory is loaded through a simple sideband write port. It is the responder counterpart of the team's AXI4 read manager, used as a bench and loop-back target and as a small on-chip lookup memory. It supports FIXED, INCR and WRAP bursts, returns one beat per cycle under continuous `rready`, and flags illegal requests and out-of-range beats with SLVERR.

## Interface
- `ADDRESS_SIZE`, default 32: AXI byte-address width.
- `DATA_SIZE`, default 32: data width in bits. Must be a power of two, at least 8.
- `DEPTH`, default 256: memory words. Must be a power of two, at least 2.
- `aclk` input 1: the single clock.
- `areset` input 1: reset, synchronous and active-high.
- `s_axi_araddr` input ADDRESS_SIZE: byte start address.
- `s_axi_arlen` input 8: beats minus 1.
- `s_axi_arsize` input 3: log2 of bytes per beat.
- `s_axi_arburst` input 2: burst type. 00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- `s_axi_arvalid` input 1: address valid.
- `s_axi_arready` output 1: address ready.
- `s_axi_rdata` output DATA_SIZE: beat data.
- `s_axi_rresp` output 2: beat response. 00 OKAY, 10 SLVERR.
- `s_axi_rlast` output 1: final beat of the burst.
- `s_axi_rvalid` output 1: beat valid.
- `s_axi_rready` input 1: manager accepts the beat.
- `mem_we` input 1: sideband write enable.
- `mem_waddr` input clog2(DEPTH): sideband word index.
- `mem_wdata` input DATA_SIZE: sideband write data.

## Operation
- Terms: B = DATA_SIZE/8; SB = log2(B); word index = addr >> SB.
- FSM states:
  - StIdle: `arready`=1.
  - StBurst: `arready`=0, beats streaming.
- StIdle -> StBurst on `arvalid && arready`. Latch the address, `arlen`, the burst type and the error flag; clear the beat counter.
- StBurst -> StIdle on `rvalid && rready && rlast`.
- Request error flag is set when any of these holds:
  - `arsize != SB`.
  - `arburst == 11`.
  - WRAP with `arlen` not in {1, 3, 7, 15}.
- Errored request: still return exactly `arlen`+1 beats. Every beat has `rresp`=SLVERR and `rdata`=0.
- Address sequence per beat:
  - FIXED: every beat uses the start address.
  - INCR: the first beat uses the start address aligned down to B; then add B per beat, modulo 2^ADDRESS_SIZE.
  - WRAP: window = (`arlen`+1)*B bytes, aligned to the window size. Add B per beat; on reaching the window top, return to the window base.
- Per-beat range check: word index ≥ DEPTH gives `rresp`=SLVERR and `rdata`=0 for that beat only. The remaining beats are unaffected.
- OKAY beats: `rdata` = mem[word index], `rresp`=00.
- `rlast`=1 exactly when beat counter == latched `arlen`.
- Sideband write: mem[`mem_waddr`] ← `mem_wdata` at the clock edge. It is accepted in any state, including during reset.
- Memory contents are not cleared by reset.

## Timing
- All AXI outputs are registered. Reset values: `arready`=0, `rvalid`=0, `rlast`=0, `rresp`=0, `rdata`=0.
- First cycle after reset is released: StIdle, with `arready`=1.
- AR handshake at cycle N: first beat presented (`rvalid`=1) at N+1.
- Beat register loads when `!rvalid || rready`. With `rready` held high, one beat per cycle with no bubbles.
- While `rvalid`=1 and `rready`=0, `rdata`, `rresp` and `rlast` are held stable.
- Final beat accepted at cycle M: `rvalid`=0 and `arready`=1 at M+1. Next AR handshake no earlier than M+1.
- Memory read/write collision: the beat register samples the memory in the cycle it loads. A sideband write to the same word in that same cycle is not seen; the old data is returned.
- Reset asserted mid-burst: the burst is abandoned. The next cycle shows reset values; no further beats of that burst are sent.
- `arlen`=0: a single beat with `rlast`=1, presented at N+1.

## Test plan
- **Single-beat INCR read.**
  - Preload mem[5]=0xDEADBEEF.
  - AR addr=0x14, len=0, size=2, burst=01.
  - Expect at N+1: `rvalid`=1, `rdata`=0xDEADBEEF, `rresp`=00, `rlast`=1.
- **INCR len=3 with `rready` toggled.**
  - Preload mem[0..3]=10, 11, 12, 13. AR addr=0x0.
  - Expect beats 10, 11, 12, 13 in order, data stable while stalled, `rlast` only on 13.
  - Expect `arready`=1 the cycle after the last handshake.
- **WRAP len=3 at addr=0x18 (window 0x10-0x1F).**
  - Expect word order 6, 7, 4, 5, all OKAY, `rlast` on word 5.
  - Repeat with FIXED, len=2: expect mem[6] three times.
- **Error cases:**
  - `arsize`=1: expect len+1 beats, all SLVERR, `rdata`=0.
  - `arburst`=11: same response.
  - WRAP with `arlen`=2: same response.
  - INCR crossing DEPTH (addr=(DEPTH-1)*4, len=1): expect beat 0 OKAY, beat 1 SLVERR.
- **Reset mid-burst:**
  - Assert `areset` after beat 1 of len=7.
  - Expect reset values next cycle, no further beats, then `arready`=1 once reset is released.
  - Expect memory contents preserved.
- **Sideband write collision:**
  - Write mem[2]=0xAA in the same cycle the beat for word 2 loads: expect the old value.
  - Read word 2 again in a new burst: expect 0xAA.
